alu_rr_sequencer: RTL and testbench
===================================

Name: alu_rr_sequencer

Overview:
- Two-requester round-robin scheduler for the shared 8-bit ALU datapath: the operand extender (OPA/OPB/carry-in, selected by a 2-bit S code) feeding an 8-bit adder.
- Accepts operation requests from two independent clients over valid/ready handshakes and grants the ALU to one client at a time.
- Drives the extender's A/B/S inputs, waits a fixed ALU latency, captures sum and carry-out, and returns a tagged response with flags over a valid/ready handshake.

Parameters:
- WIDTH, 8, datapath width of operands and result.
- ALU_LAT, 1, cycles from driving alu_a/alu_b/alu_s to a valid alu_sum/alu_cout; legal range 1..7.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_op  input  2  requester 0 S code: 00 A+B, 01 A-B, 10 A+1, 11 pass A.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready: same as requester 0, for requester 1.
- alu_a  output  WIDTH  operand A to the extender.
- alu_b  output  WIDTH  operand B to the extender.
- alu_s  output  2  S select to the extender.
- alu_sum  input  WIDTH  adder sum.
- alu_cout  input  1  adder carry-out.
- rsp_valid  output  1  response available.
- rsp_id  output  1  requester that owns the response.
- rsp_data  output  WIDTH  captured sum.
- rsp_cout  output  1  captured carry-out.
- rsp_zero  output  1  high when rsp_data == 0.
- rsp_ready  input  1  consumer accepts the response.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Handshake: a request transfers when reqN_valid && reqN_ready are high on the same rising edge. The response transfers when rsp_valid && rsp_ready are high on the same rising edge.
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, last_grant=1, so requester 0 wins first.
  - All outputs 0: req*_ready, alu_a, alu_b, alu_s, rsp_*, busy.
  - Reset mid-operation abandons the in-flight operation; no response is emitted.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: high only for the granted requester, and only in IDLE.
  - Grant when only one requester is valid: that requester.
  - Grant when both are valid: the requester != last_grant.
  - On acceptance: latch op/a/b and the id into internal registers, set last_grant=id, load the wait counter with ALU_LAT, go to EXEC.
  - No valid requester: stay in IDLE with both readys low.
- EXEC:
  - alu_a, alu_b, alu_s are driven from the latched registers and held stable for the whole state.
  - The counter decrements once per cycle. On the cycle the counter reads 1, capture alu_sum→rsp_data and alu_cout→rsp_cout, compute rsp_zero, and go to RESP.
  - EXEC therefore lasts exactly ALU_LAT cycles.
- RESP:
  - rsp_valid=1; rsp_id/data/cout/zero are held stable until the transfer.
  - On rsp_ready: rsp_valid drops the next cycle and the FSM returns to IDLE.
  - A new request can be accepted no earlier than the cycle after the response transfer (no overlap).
- alu_a/alu_b/alu_s keep their last values outside EXEC; there is no glitch requirement.
- Request changes: requester inputs may change freely while not granted. A request held valid across a loss is served on the next arbitration, which is guaranteed by round-robin.
- Arithmetic: results wrap modulo 2^WIDTH. Flags are taken purely from the captured values, with no reinterpretation.
  - For 01 (subtract), rsp_cout=1 means no borrow (A>=B).
- Minimum throughput: one operation per ALU_LAT+2 cycles, given rsp_ready held high.

Test Plan:
- Reset then single add: req0 op=00 a=0x12 b=0x34, ALU_LAT=1, model adder → rsp_valid 2 cycles after acceptance, rsp_id=0, data=0x46, cout=0, zero=0.
- Subtract borrow/no-borrow: req1 op=01 a=0x05 b=0x07 → data=0xFE, cout=0. Then a=0x07 b=0x07 → data=0x00, cout=1, zero=1.
- Increment wrap and pass: op=10 a=0xFF → data=0x00, cout=1, zero=1. op=11 a=0xA5 b=0x3C → data=0xA5, cout=0.
- Contention fairness: both valid continuously for 6 operations → grant order 0,1,0,1,0,1; req*_ready never high in EXEC/RESP.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp fields stable, no request accepted, busy=1; rsp_ready=1 → IDLE next cycle.
- Reset mid-EXEC with ALU_LAT=3: assert rst in the 2nd EXEC cycle → next cycle IDLE, all outputs 0, no rsp_valid. Next contention is granted to requester 0.

Source files
------------

// File: rtl/alu_rr_if.sv
// Bundle of the request, ALU-side and response signals of the round-robin ALU sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface alu_rr_if #(
    parameter int WIDTH = 8
) ();
    logic             req0_valid;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_s;
    logic [WIDTH-1:0] alu_sum;
    logic             alu_cout;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_cout;
    logic             rsp_zero;
    logic             rsp_ready;

    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_a, alu_b, alu_s,
        input  alu_sum, alu_cout,
        output rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zero,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_a, alu_b, alu_s,
        output alu_sum, alu_cout,
        input  rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zero,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_rr_sequencer.sv
// Two-client round-robin scheduler for the shared operand-extender/adder datapath:
// grants one request at a time, waits ALU_LAT cycles, and returns a tagged, flagged result.
module alu_rr_sequencer #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input logic     clk,
    input logic     rst,
    alu_rr_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic             capture;
    logic             ready0;
    logic             ready1;
    logic [2:0]       cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_s;
    logic             cur_id;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_cout;
    logic             rsp_zero;

    // Round-robin pick: a lone requester always wins; on contention the one not served last wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant;
        end else if (bus.req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        ready0    = 1'b0;
        ready1    = 1'b0;
        case (state)
            IDLE: begin
                // Ready is withheld during reset so nothing appears accepted on a reset edge.
                if (grant_vld && !rst) begin
                    ready0    = ~grant_id;
                    ready1    = grant_id;
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 3'd1) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            cnt        <= 3'd0;
            op_a       <= '0;
            op_b       <= '0;
            op_s       <= 2'b00;
            cur_id     <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_cout   <= 1'b0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                op_a       <= grant_id ? bus.req1_a  : bus.req0_a;
                op_b       <= grant_id ? bus.req1_b  : bus.req0_b;
                op_s       <= grant_id ? bus.req1_op : bus.req0_op;
                cur_id     <= grant_id;
                last_grant <= grant_id;
                cnt        <= 3'(ALU_LAT);
            end else if (state == EXEC) begin
                cnt <= cnt - 3'd1;
            end
            // Last EXEC cycle: the adder output has had ALU_LAT cycles to settle.
            if (capture) begin
                rsp_id   <= cur_id;
                rsp_data <= bus.alu_sum;
                rsp_cout <= bus.alu_cout;
                rsp_zero <= (bus.alu_sum == '0);
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.alu_a      = op_a;
    assign bus.alu_b      = op_b;
    assign bus.alu_s      = op_s;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_data   = rsp_data;
    assign bus.rsp_cout   = rsp_cout;
    assign bus.rsp_zero   = rsp_zero;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: two instances (ALU_LAT=1 and 3) share stimulus; a transaction-level
// model (outstanding flag, age, last winner) predicts every output of the selected instance.
module tb_alu_rr_sequencer;
    logic clk;
    logic rst;

    alu_rr_if #(.WIDTH(8)) bus1 ();
    alu_rr_if #(.WIDTH(8)) bus3 ();

    alu_rr_sequencer #(.WIDTH(8), .ALU_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    alu_rr_sequencer #(.WIDTH(8), .ALU_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand extender + adder: S selects B, ~B with carry-in, +1, or pass A.
    function automatic logic [8:0] ext_add(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] bx;
        logic       cin;
        case (s)
            2'b00:   begin bx = b;     cin = 1'b0; end
            2'b01:   begin bx = ~b;    cin = 1'b1; end
            2'b10:   begin bx = 8'h00; cin = 1'b1; end
            default: begin bx = 8'h00; cin = 1'b0; end
        endcase
        return {1'b0, a} + {1'b0, bx} + {8'h00, cin};
    endfunction

    // Expected result from plain integer arithmetic: {cout, data}.
    function automatic logic [8:0] ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int   ia;
        int   ib;
        int   r;
        logic c;
        ia = int'(a);
        ib = int'(b);
        case (op)
            2'b00:   begin r = ia + ib; c = (r > 255);  end
            2'b01:   begin r = ia - ib; c = (ia >= ib); end
            2'b10:   begin r = ia + 1;  c = (r > 255);  end
            default: begin r = ia;      c = 1'b0;       end
        endcase
        return {c, 8'(r & 255)};
    endfunction

    assign {bus1.alu_cout, bus1.alu_sum} = ext_add(bus1.alu_s, bus1.alu_a, bus1.alu_b);
    assign {bus3.alu_cout, bus3.alu_sum} = ext_add(bus3.alu_s, bus3.alu_a, bus3.alu_b);

    // Staged stimulus (t_*) is copied to the driven signals (d_*) at the start of each step.
    logic       t_v0, t_v1, t_rr, d_v0, d_v1, d_rr;
    logic [1:0] t_op0, t_op1, d_op0, d_op1;
    logic [7:0] t_a0, t_b0, t_a1, t_b1, d_a0, d_b0, d_a1, d_b1;

    assign bus1.req0_valid = d_v0;  assign bus3.req0_valid = d_v0;
    assign bus1.req0_op    = d_op0; assign bus3.req0_op    = d_op0;
    assign bus1.req0_a     = d_a0;  assign bus3.req0_a     = d_a0;
    assign bus1.req0_b     = d_b0;  assign bus3.req0_b     = d_b0;
    assign bus1.req1_valid = d_v1;  assign bus3.req1_valid = d_v1;
    assign bus1.req1_op    = d_op1; assign bus3.req1_op    = d_op1;
    assign bus1.req1_a     = d_a1;  assign bus3.req1_a     = d_a1;
    assign bus1.req1_b     = d_b1;  assign bus3.req1_b     = d_b1;
    assign bus1.rsp_ready  = d_rr;  assign bus3.rsp_ready  = d_rr;

    logic       sel;
    int         lat;
    logic       o_r0, o_r1, o_rv, o_id, o_cout, o_zero, o_busy;
    logic [7:0] o_alu_a, o_alu_b, o_data;
    logic [1:0] o_alu_s;

    assign o_r0    = sel ? bus3.req0_ready : bus1.req0_ready;
    assign o_r1    = sel ? bus3.req1_ready : bus1.req1_ready;
    assign o_rv    = sel ? bus3.rsp_valid  : bus1.rsp_valid;
    assign o_id    = sel ? bus3.rsp_id     : bus1.rsp_id;
    assign o_data  = sel ? bus3.rsp_data   : bus1.rsp_data;
    assign o_cout  = sel ? bus3.rsp_cout   : bus1.rsp_cout;
    assign o_zero  = sel ? bus3.rsp_zero   : bus1.rsp_zero;
    assign o_busy  = sel ? bus3.busy       : bus1.busy;
    assign o_alu_a = sel ? bus3.alu_a      : bus1.alu_a;
    assign o_alu_b = sel ? bus3.alu_b      : bus1.alu_b;
    assign o_alu_s = sel ? bus3.alu_s      : bus1.alu_s;

    int total;
    int bad;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model state.
    logic       m_out, m_last, m_id, m_cout;
    int         m_age;
    logic [1:0] m_op;
    logic [7:0] m_a, m_b, m_data;

    // Step results.
    int         g_gnt;
    logic       g_rsp, g_id, g_cout, g_zero;
    logic [7:0] g_data;

    task automatic model_reset();
        m_out  = 1'b0;
        m_last = 1'b1;
        m_age  = 0;
    endtask

    task automatic step();
        logic exp_r0, exp_r1, exp_rv;
        logic [8:0] rr;
        @(negedge clk);
        d_v0 = t_v0; d_op0 = t_op0; d_a0 = t_a0; d_b0 = t_b0;
        d_v1 = t_v1; d_op1 = t_op1; d_a1 = t_a1; d_b1 = t_b1;
        d_rr = t_rr;
        #1;
        if (m_out) m_age++;
        g_gnt = -1;
        g_rsp = 1'b0;
        exp_r0 = !m_out && d_v0 && (!d_v1 || m_last);
        exp_r1 = !m_out && d_v1 && (!d_v0 || !m_last);
        exp_rv = m_out && (m_age >= lat + 1);
        check("req0_ready", 32'(o_r0), 32'(exp_r0));
        check("req1_ready", 32'(o_r1), 32'(exp_r1));
        check("busy", 32'(o_busy), 32'(m_out));
        check("rsp_valid", 32'(o_rv), 32'(exp_rv));
        if (m_out && m_age <= lat) begin
            check("alu_a", 32'(o_alu_a), 32'(m_a));
            check("alu_b", 32'(o_alu_b), 32'(m_b));
            check("alu_s", 32'(o_alu_s), 32'(m_op));
        end
        if (exp_rv) begin
            check("rsp_id", 32'(o_id), 32'(m_id));
            check("rsp_data", 32'(o_data), 32'(m_data));
            check("rsp_cout", 32'(o_cout), 32'(m_cout));
            check("rsp_zero", 32'(o_zero), 32'(m_data == 8'h00));
        end
        if (exp_rv && d_rr) begin
            m_out  = 1'b0;
            g_rsp  = 1'b1;
            g_id   = o_id;
            g_data = o_data;
            g_cout = o_cout;
            g_zero = o_zero;
        end else if (exp_r0 || exp_r1) begin
            m_id   = exp_r1;
            m_last = exp_r1;
            m_op   = exp_r1 ? d_op1 : d_op0;
            m_a    = exp_r1 ? d_a1  : d_a0;
            m_b    = exp_r1 ? d_b1  : d_b0;
            rr     = ref_result(m_op, m_a, m_b);
            m_cout = rr[8];
            m_data = rr[7:0];
            m_out  = 1'b1;
            m_age  = 0;
            g_gnt  = exp_r1 ? 1 : 0;
        end
    endtask

    task automatic idle_stim();
        t_v0 = 1'b0; t_v1 = 1'b0; t_rr = 1'b1;
        t_op0 = 2'b00; t_a0 = 8'h00; t_b0 = 8'h00;
        t_op1 = 2'b00; t_a1 = 8'h00; t_b1 = 8'h00;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        idle_stim();
        d_v0 = 1'b0; d_v1 = 1'b0; d_rr = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check({tag, "_ready0"}, 32'(o_r0), 0);
        check({tag, "_ready1"}, 32'(o_r1), 0);
        check({tag, "_alu_a"}, 32'(o_alu_a), 0);
        check({tag, "_alu_b"}, 32'(o_alu_b), 0);
        check({tag, "_alu_s"}, 32'(o_alu_s), 0);
        check({tag, "_rsp_valid"}, 32'(o_rv), 0);
        check({tag, "_rsp_data"}, 32'(o_data), 0);
        check({tag, "_rsp_flags"}, 32'({o_id, o_cout, o_zero}), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] data;
        logic       cout;
        logic       zero;
    } vec_t;

    vec_t vecs[8];
    int   n_gnt;
    bit   done;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        sel   = 1'b0;
        lat   = 1;
        idle_stim();
        d_v0 = 1'b0; d_v1 = 1'b0; d_rr = 1'b1;
        d_op0 = 2'b00; d_a0 = 8'h00; d_b0 = 8'h00;
        d_op1 = 2'b00; d_a1 = 8'h00; d_b1 = 8'h00;
        model_reset();

        vecs[0] = '{1'b0, 2'b00, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 2'b01, 8'h07, 8'h07, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 2'b10, 8'hFF, 8'h5A, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 2'b11, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 2'b00, 8'h80, 8'h7F, 8'hFF, 1'b0, 1'b0};

        do_reset("reset1");

        // Table vectors on the ALU_LAT=1 instance, one requester at a time.
        foreach (vecs[i]) begin
            idle_stim();
            if (vecs[i].id) begin
                t_v1 = 1'b1; t_op1 = vecs[i].op; t_a1 = vecs[i].a; t_b1 = vecs[i].b;
            end else begin
                t_v0 = 1'b1; t_op0 = vecs[i].op; t_a0 = vecs[i].a; t_b0 = vecs[i].b;
            end
            step();
            check("vec_grant", 32'(g_gnt), 32'(vecs[i].id));
            idle_stim();
            done = 1'b0;
            for (int k = 0; k < 10 && !done; k++) begin
                step();
                if (g_rsp) done = 1'b1;
            end
            check("vec_rsp_seen", 32'(done), 1);
            if (done) begin
                check("vec_id", 32'(g_id), 32'(vecs[i].id));
                check("vec_data", 32'(g_data), 32'(vecs[i].data));
                check("vec_cout", 32'(g_cout), 32'(vecs[i].cout));
                check("vec_zero", 32'(g_zero), 32'(vecs[i].zero));
            end
            step();
        end

        // Contention straight after reset: grants alternate starting with requester 0.
        do_reset("reset2");
        t_v0 = 1'b1; t_op0 = 2'b00; t_a0 = 8'h10; t_b0 = 8'h01;
        t_v1 = 1'b1; t_op1 = 2'b01; t_a1 = 8'h20; t_b1 = 8'h02;
        t_rr = 1'b1;
        n_gnt = 0;
        for (int k = 0; k < 60 && n_gnt < 6; k++) begin
            step();
            if (g_gnt >= 0) begin
                check("fair_order", 32'(g_gnt), 32'(n_gnt % 2));
                n_gnt++;
            end
        end
        check("fair_count", 32'(n_gnt), 6);

        // Backpressure: response held 5 cycles with both requesters pending.
        do_reset("reset3");
        t_v0 = 1'b1; t_op0 = 2'b00; t_a0 = 8'hC0; t_b0 = 8'h40;
        t_rr = 1'b0;
        step();
        check("bp_grant", 32'(g_gnt), 0);
        t_v1 = 1'b1; t_op1 = 2'b10; t_a1 = 8'h33;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            step();
            if (o_rv) done = 1'b1;
        end
        check("bp_rsp_seen", 32'(done), 1);
        n_gnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (g_gnt >= 0) n_gnt++;
        end
        check("bp_no_accept", 32'(n_gnt), 0);
        check("bp_busy", 32'(o_busy), 1);
        t_v0 = 1'b0; t_v1 = 1'b0; t_rr = 1'b1;
        step();
        check("bp_transfer", 32'(g_rsp), 1);
        step();
        check("bp_idle", 32'(o_busy), 0);

        // Randomized traffic on both latencies.
        for (int pass = 0; pass < 2; pass++) begin
            sel = pass[0];
            lat = pass[0] ? 3 : 1;
            do_reset("reset_rand");
            for (int k = 0; k < 300; k++) begin
                t_v0  = ($urandom_range(0, 2) != 0);
                t_v1  = ($urandom_range(0, 2) != 0);
                t_op0 = 2'($urandom_range(0, 3));
                t_op1 = 2'($urandom_range(0, 3));
                t_a0  = 8'($urandom); t_b0 = 8'($urandom);
                t_a1  = 8'($urandom); t_b1 = 8'($urandom);
                t_rr  = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        // Reset during the second EXEC cycle of an ALU_LAT=3 operation.
        sel = 1'b1;
        lat = 3;
        do_reset("reset4");
        t_v0 = 1'b1; t_op0 = 2'b00; t_a0 = 8'h11; t_b0 = 8'h22;
        step();
        check("mid_grant", 32'(g_gnt), 0);
        idle_stim();
        step();
        @(negedge clk);
        d_v0 = 1'b0; d_v1 = 1'b0; d_rr = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_busy", 32'(o_busy), 0);
        check("mid_rsp_valid", 32'(o_rv), 0);
        check("mid_alu", 32'({o_alu_a, o_alu_b, o_alu_s}), 0);
        check("mid_rsp_data", 32'(o_data), 0);
        check("mid_ready", 32'({o_r0, o_r1}), 0);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) step();
        t_v0 = 1'b1; t_v1 = 1'b1;
        step();
        check("mid_after_grant", 32'(g_gnt), 0);
        idle_stim();
        for (int k = 0; k < 8; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
